// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared constants for the fetch/memory-stage port arbiter.
//               Holds the memory geometry, access widths, the starvation
//               limit and the arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    // Byte size of the shared memory behind the single port
    localparam int MEM_BYTES   = 1024;

    // Consecutive data grants tolerated while a fetch is waiting
    localparam int STARVE_MAX  = 4;

    // Bytes returned to fetch (longest instruction) and moved by data accesses
    localparam int INSTR_BYTES = 10;
    localparam int WORD_BYTES  = 8;

    // Arbiter state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY_I = 2'd1;
    localparam logic [1:0] ST_BUSY_D = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_bounds_chk.sv
`default_nettype none
// ============================================================================
// Module      : mem_bounds_chk
// Description : Combinational range check of a multi-byte access. Flags an
//               access whose last byte would fall beyond the memory size.
//               The sum is formed one bit wider than the address so that
//               addresses near 2^64 cannot wrap into range.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bounds_chk #(
    parameter int MEM_BYTES = 1024,
    parameter int ACC_BYTES = 8
) (
    input  logic [63:0] i_addr,
    output logic        o_oor
);

    logic [64:0] w_end;

    assign w_end = {1'b0, i_addr} + 65'(ACC_BYTES);
    assign o_oor = (w_end > 65'(MEM_BYTES));

endmodule : mem_bounds_chk
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Arbitrates one memory port between the instruction fetch
//               stage and the memory stage. Data accesses normally win; a
//               fetch is forced through after STARVE_MAX consecutive data
//               grants taken while it was waiting. Out-of-range accesses are
//               answered with an error strobe and never reach memory.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int MEM_BYTES  = mem_port_arbiter_pkg::MEM_BYTES,
    parameter int STARVE_MAX = mem_port_arbiter_pkg::STARVE_MAX
) (
    input  logic        clk,
    input  logic        rst_n,

    // Fetch requester
    input  logic        i_req,
    input  logic [63:0] i_addr,
    output logic        i_valid,
    output logic [79:0] i_rdata,
    output logic        i_err,
    output logic        i_stall,

    // Memory-stage requester
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_valid,
    output logic [63:0] d_rdata,
    output logic        d_err,
    output logic        d_stall,

    // Shared memory port
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [79:0] mem_rdata
);

    import mem_port_arbiter_pkg::*;

    // Counter must be able to hold STARVE_MAX; keep at least one bit
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_starve_cnt;

    logic             r_mem_req;
    logic             r_mem_we;
    logic [63:0]      r_mem_addr;
    logic [63:0]      r_mem_wdata;

    logic             r_i_valid;
    logic [79:0]      r_i_rdata;
    logic             r_i_err;
    logic             r_d_valid;
    logic [63:0]      r_d_rdata;
    logic             r_d_err;

    logic             w_i_oor;
    logic             w_d_oor;
    logic             w_idle;
    logic             w_i_win;
    logic             w_d_win;
    logic             w_i_go;
    logic             w_d_go;
    logic             w_acc_done;

    // ------------------------------------------------------------------
    // Address range checks, one per requester
    // ------------------------------------------------------------------
    mem_bounds_chk #(
        .MEM_BYTES (MEM_BYTES),
        .ACC_BYTES (INSTR_BYTES)
    ) u_i_bounds (
        .i_addr (i_addr),
        .o_oor  (w_i_oor)
    );

    mem_bounds_chk #(
        .MEM_BYTES (MEM_BYTES),
        .ACC_BYTES (WORD_BYTES)
    ) u_d_bounds (
        .i_addr (d_addr),
        .o_oor  (w_d_oor)
    );

    // ------------------------------------------------------------------
    // Arbitration: only meaningful in IDLE. Fetch wins when alone or when
    // the memory stage has already taken STARVE_MAX grants in a row.
    // ------------------------------------------------------------------
    assign w_idle     = (r_state == ST_IDLE);
    assign w_i_win    = i_req & (~d_req | (r_starve_cnt == STARVE_LIM));
    assign w_d_win    = d_req & ~w_i_win;
    assign w_i_go     = w_idle & w_i_win & ~w_i_oor;
    assign w_d_go     = w_idle & w_d_win & ~w_d_oor;
    assign w_acc_done = mem_ready &
                        ((r_state == ST_BUSY_I) | (r_state == ST_BUSY_D));

    // State sequencing and starvation counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_starve_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_d_win) begin
                        r_state <= w_d_oor ? ST_DONE : ST_BUSY_D;
                        if (i_req) begin
                            if (r_starve_cnt != STARVE_LIM) begin
                                r_starve_cnt <= r_starve_cnt + CNT_W'(1);
                            end
                        end else begin
                            r_starve_cnt <= '0;
                        end
                    end else if (w_i_win) begin
                        r_state      <= w_i_oor ? ST_DONE : ST_BUSY_I;
                        r_starve_cnt <= '0;
                    end
                end
                ST_BUSY_I,
                ST_BUSY_D: begin
                    if (mem_ready) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory port command: captured at the grant, held until completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_d_go) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= d_we;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
        end else if (w_i_go) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= i_addr;
            r_mem_wdata <= '0;
        end else if (w_acc_done) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
        end
    end

    // Response strobes, read data capture and error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i_valid <= 1'b0;
            r_i_rdata <= '0;
            r_i_err   <= 1'b0;
            r_d_valid <= 1'b0;
            r_d_rdata <= '0;
            r_d_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Rejected accesses skip memory and answer next cycle
                    if (w_d_win && w_d_oor) begin
                        r_d_valid <= 1'b1;
                        r_d_err   <= 1'b1;
                    end else if (!w_d_win && w_i_win && w_i_oor) begin
                        r_i_valid <= 1'b1;
                        r_i_err   <= 1'b1;
                    end
                end
                ST_BUSY_I: begin
                    if (mem_ready) begin
                        r_i_valid <= 1'b1;
                        r_i_err   <= 1'b0;
                        r_i_rdata <= mem_rdata;
                    end
                end
                ST_BUSY_D: begin
                    if (mem_ready) begin
                        r_d_valid <= 1'b1;
                        r_d_err   <= 1'b0;
                        // Writes leave the previous read data in place
                        if (!r_mem_we) begin
                            r_d_rdata <= mem_rdata[79:16];
                        end
                    end
                end
                ST_DONE: begin
                    r_i_valid <= 1'b0;
                    r_i_err   <= 1'b0;
                    r_d_valid <= 1'b0;
                    r_d_err   <= 1'b0;
                end
                default: begin
                    r_i_valid <= 1'b0;
                    r_d_valid <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    assign i_valid   = r_i_valid;
    assign i_rdata   = r_i_rdata;
    assign i_err     = r_i_err;
    assign d_valid   = r_d_valid;
    assign d_rdata   = r_d_rdata;
    assign d_err     = r_d_err;

    // Requesters stall until their own response strobe
    assign i_stall   = i_req & ~r_i_valid;
    assign d_stall   = d_req & ~r_d_valid;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter with a
//               programmable-latency memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [63:0] i_addr;
    logic        i_valid;
    logic [79:0] i_rdata;
    logic        i_err;
    logic        i_stall;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_valid;
    logic [63:0] d_rdata;
    logic        d_err;
    logic        d_stall;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ready;
    logic [79:0] mem_rdata;

    int          n_checks;
    int          n_fails;

    // Responder controls and observations
    int          rsp_lat;
    logic [79:0] rsp_rdata;
    int          busy_cnt;
    int          mreq_cycles;
    bit          addr_moved;
    logic [63:0] first_addr;
    logic [63:0] wr_addr;
    logic [63:0] wr_data;

    mem_port_arbiter #(
        .MEM_BYTES  (1024),
        .STARVE_MAX (4)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_valid   (i_valid),
        .i_rdata   (i_rdata),
        .i_err     (i_err),
        .i_stall   (i_stall),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_valid   (d_valid),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .d_stall   (d_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = rsp_rdata;

    task automatic check_eq(input string tag, input logic [79:0] act,
                            input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Wait (bounded) for a response strobe on the chosen side
    task automatic wait_valid(input string tag, input bit side_d,
                              input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (side_d ? d_valid : i_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq(tag, 80'(seen), 80'd1);
    endtask

    // Memory responder: mem_ready in the rsp_lat-th cycle of mem_req
    initial begin
        mem_ready   = 1'b0;
        busy_cnt    = 0;
        mreq_cycles = 0;
        addr_moved  = 1'b0;
        first_addr  = '0;
        wr_addr     = '0;
        wr_data     = '0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                mreq_cycles++;
                if (busy_cnt == 0) first_addr = mem_addr;
                else if (mem_addr !== first_addr) addr_moved = 1'b1;
                mem_ready = (busy_cnt == rsp_lat - 1);
                if (mem_ready && mem_we) begin
                    wr_addr = mem_addr;
                    wr_data = mem_wdata;
                end
                busy_cnt++;
            end else begin
                mem_ready = 1'b0;
                busy_cnt  = 0;
            end
        end
    end

    initial begin
        int dcnt;
        int runs;
        int stall_cyc;
        int vcnt;

        n_checks  = 0;
        n_fails   = 0;
        rst_n     = 1'b0;
        i_req     = 1'b0;
        i_addr    = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        rsp_lat   = 1;
        rsp_rdata = '0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check_eq("rst_mem_req", 80'(mem_req), 80'd0);
        check_eq("rst_i_valid", 80'(i_valid), 80'd0);
        check_eq("rst_d_valid", 80'(d_valid), 80'd0);
        check_eq("rst_mem_addr", 80'(mem_addr), 80'd0);
        check_eq("rst_i_rdata", i_rdata, 80'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- single fetch, latency 1 ----------------
        rsp_rdata = 80'h30F2_0400_0000_0000_0002;
        i_addr    = 64'd4;
        i_req     = 1'b1;
        #1;
        check_eq("f1_i_stall", 80'(i_stall), 80'd1);
        check_eq("f1_d_stall", 80'(d_stall), 80'd0);
        @(negedge clk);
        check_eq("f1_mem_req", 80'(mem_req), 80'd1);
        check_eq("f1_mem_we", 80'(mem_we), 80'd0);
        check_eq("f1_mem_addr", 80'(mem_addr), 80'd4);
        @(negedge clk);
        check_eq("f1_i_valid", 80'(i_valid), 80'd1);
        check_eq("f1_i_rdata", i_rdata, 80'h30F2_0400_0000_0000_0002);
        check_eq("f1_i_err", 80'(i_err), 80'd0);
        check_eq("f1_d_valid", 80'(d_valid), 80'd0);
        check_eq("f1_stall_done", 80'(i_stall), 80'd0);
        i_req = 1'b0;
        @(negedge clk);
        check_eq("f1_valid_pulse", 80'(i_valid), 80'd0);
        check_eq("f1_mem_req_off", 80'(mem_req), 80'd0);

        // ---------------- collision: data write first ----------------
        i_addr  = 64'd8;
        i_req   = 1'b1;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 64'd1;
        d_wdata = 64'd5;
        @(negedge clk);
        check_eq("col_mem_req", 80'(mem_req), 80'd1);
        check_eq("col_mem_we", 80'(mem_we), 80'd1);
        check_eq("col_mem_addr", 80'(mem_addr), 80'd1);
        check_eq("col_mem_wdata", 80'(mem_wdata), 80'd5);
        @(negedge clk);
        check_eq("col_d_valid", 80'(d_valid), 80'd1);
        check_eq("col_i_wait", 80'(i_valid), 80'd0);
        d_req = 1'b0;
        d_we  = 1'b0;
        @(negedge clk);
        check_eq("col_i_stall", 80'(i_stall), 80'd1);
        @(negedge clk);
        check_eq("col_f_mem_we", 80'(mem_we), 80'd0);
        check_eq("col_f_mem_addr", 80'(mem_addr), 80'd8);
        @(negedge clk);
        check_eq("col_i_valid", 80'(i_valid), 80'd1);
        i_req = 1'b0;
        @(negedge clk);

        // ---------------- starvation: 4 data grants per fetch ----------------
        rsp_rdata = 80'h0123_4567_89AB_CDEF_5555;
        i_addr    = 64'd16;
        d_addr    = 64'd32;
        d_we      = 1'b0;
        i_req     = 1'b1;
        d_req     = 1'b1;
        dcnt      = 0;
        runs      = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (d_valid) begin
                dcnt++;
                if (dcnt == 1 && runs == 0)
                    check_eq("stv_d_rdata", 80'(d_rdata), 80'h0123_4567_89AB_CDEF);
            end
            if (i_valid) begin
                check_eq("stv_data_grants", 80'(dcnt), 80'd4);
                dcnt = 0;
                runs++;
                if (runs == 2) begin
                    i_req = 1'b0;
                    d_req = 1'b0;
                    break;
                end
            end
        end
        check_eq("stv_rounds", 80'(runs), 80'd2);
        @(negedge clk);

        // ---------------- bounds ----------------
        mreq_cycles = 0;
        d_addr = 64'd1020;
        d_req  = 1'b1;
        wait_valid("bnd_d_oor_valid", 1'b1, 5);
        check_eq("bnd_d_err", 80'(d_err), 80'd1);
        check_eq("bnd_d_rdata_hold", 80'(d_rdata), 80'h0123_4567_89AB_CDEF);
        d_req = 1'b0;
        @(negedge clk);
        check_eq("bnd_d_no_mem_req", 80'(mreq_cycles), 80'd0);

        d_addr  = 64'd1016;
        d_we    = 1'b1;
        d_wdata = 64'h1122_3344_5566_7788;
        d_req   = 1'b1;
        wait_valid("bnd_d_edge_valid", 1'b1, 10);
        check_eq("bnd_d_edge_err", 80'(d_err), 80'd0);
        d_req = 1'b0;
        d_we  = 1'b0;
        @(negedge clk);

        i_addr = 64'd1014;
        i_req  = 1'b1;
        wait_valid("bnd_i_1014_valid", 1'b0, 10);
        check_eq("bnd_i_1014_err", 80'(i_err), 80'd0);
        i_req = 1'b0;
        @(negedge clk);

        mreq_cycles = 0;
        i_addr = 64'd1015;
        i_req  = 1'b1;
        wait_valid("bnd_i_1015_valid", 1'b0, 5);
        check_eq("bnd_i_1015_err", 80'(i_err), 80'd1);
        i_req = 1'b0;
        @(negedge clk);
        check_eq("bnd_i_no_mem_req", 80'(mreq_cycles), 80'd0);

        // ---------------- variable latency write ----------------
        rsp_lat    = 6;
        addr_moved = 1'b0;
        d_addr     = 64'd100;
        d_we       = 1'b1;
        d_wdata    = 64'hDEAD_BEEF_0000_0100;
        d_req      = 1'b1;
        stall_cyc  = 0;
        vcnt       = 0;
        #1;
        for (int c = 0; c < 12; c++) begin
            if (d_stall) stall_cyc++;
            if (d_valid) begin
                vcnt++;
                d_req = 1'b0;
                d_we  = 1'b0;
            end
            @(negedge clk);
        end
        check_eq("lat_stall_cycles", 80'(stall_cyc), 80'd7);
        check_eq("lat_valid_pulses", 80'(vcnt), 80'd1);
        check_eq("lat_addr_stable", 80'(addr_moved), 80'd0);
        check_eq("lat_wr_addr", 80'(wr_addr), 80'd100);
        check_eq("lat_wr_data", 80'(wr_data), 80'hDEAD_BEEF_0000_0100);

        // ---------------- reset during a stalled access ----------------
        rsp_lat = 1000;
        d_addr  = 64'd200;
        d_we    = 1'b1;
        d_wdata = 64'd7;
        d_req   = 1'b1;
        @(negedge clk);
        check_eq("rma_busy", 80'(mem_req), 80'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rma_mem_req", 80'(mem_req), 80'd0);
        check_eq("rma_mem_we", 80'(mem_we), 80'd0);
        check_eq("rma_mem_addr", 80'(mem_addr), 80'd0);
        check_eq("rma_mem_wdata", 80'(mem_wdata), 80'd0);
        check_eq("rma_i_rdata", i_rdata, 80'd0);
        check_eq("rma_d_rdata", 80'(d_rdata), 80'd0);
        d_req = 1'b0;
        d_we  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_lat   = 1;
        rsp_rdata = 80'hA1B2_C3D4_E5F6_0718_293A;
        @(negedge clk);
        i_addr = 64'd0;
        i_req  = 1'b1;
        @(negedge clk);
        check_eq("rma_f_mem_req", 80'(mem_req), 80'd1);
        check_eq("rma_f_mem_addr", 80'(mem_addr), 80'd0);
        @(negedge clk);
        check_eq("rma_f_i_valid", 80'(i_valid), 80'd1);
        check_eq("rma_f_i_rdata", i_rdata, 80'hA1B2_C3D4_E5F6_0718_293A);
        i_req = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
